// File: rtl/mem_boot_loader_pkg.sv
// Shared types for the boot loader: session states and stream target encodings.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE,
        ERROR
    } boot_state_e;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

endpackage

// File: rtl/mem_boot_loader_if.sv
// Valid/ready word stream feeding the boot loader; master is the host source.
interface mem_boot_loader_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_target;
    logic              in_last;

    modport master (
        output in_valid, in_data, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_data, in_target, in_last,
        output in_ready
    );
endinterface

// File: rtl/mem_boot_loader_wr_port.sv
// One auto-incrementing memory write port: pointer, overflow detect, registered write strobe.
module boot_wr_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              acc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W:0]   ptr_q;
    logic [ADDR_W:0]   ptr_d;
    logic              write;

    assign full_o = (ptr_q >= DEPTH_C);
    assign write  = acc_i && !full_o;
    assign ptr_d  = ptr_q + 1'b1;

    // The pointer doubles as the written-word count, so count updates with the we pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
        end else begin
            we_q <= write;
            if (clr_i) begin
                ptr_q <= '0;
            end else if (write) begin
                addr_q  <= ptr_q[ADDR_W-1:0];
                wdata_q <= data_i;
                ptr_q   <= ptr_d;
            end
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign count_o = ptr_q;

endmodule

// File: rtl/mem_boot_loader.sv
// Streams a boot image into instruction/data memories, then releases the core via cpu_run.
module mem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned IMEM_DEPTH = 128,
    parameter int unsigned DMEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    mem_boot_loader_if.slave  stream,
    output logic [DATA_W-1:0] imem_wdata,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [ADDR_W:0]   imem_count,
    output logic [ADDR_W:0]   dmem_count,
    output logic              busy,
    output logic              cpu_run,
    output logic              err
);
    boot_state_e state_q;
    logic        busy_q;
    logic        cpu_run_q;
    logic        err_q;

    logic accept;
    logic acc_imem;
    logic acc_dmem;
    logic full_imem;
    logic full_dmem;
    logic overflow;
    logic session_clr;

    assign stream.in_ready = (state_q == LOAD);
    assign accept          = stream.in_ready && stream.in_valid;
    assign acc_imem        = accept && (stream.in_target == TGT_IMEM);
    assign acc_dmem        = accept && (stream.in_target == TGT_DMEM);
    assign overflow        = (acc_imem && full_imem) || (acc_dmem && full_dmem);
    assign session_clr     = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);

    boot_wr_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(IMEM_DEPTH)) u_imem_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (session_clr),
        .acc_i   (acc_imem),
        .data_i  (stream.in_data),
        .we_o    (imem_we),
        .addr_o  (imem_addr),
        .wdata_o (imem_wdata),
        .count_o (imem_count),
        .full_o  (full_imem)
    );

    boot_wr_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DMEM_DEPTH)) u_dmem_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (session_clr),
        .acc_i   (acc_dmem),
        .data_i  (stream.in_data),
        .we_o    (dmem_we),
        .addr_o  (dmem_addr),
        .wdata_o (dmem_wdata),
        .count_o (dmem_count),
        .full_o  (full_dmem)
    );

    // DRAIN covers the cycle of the final write pulse so cpu_run rises one cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cpu_run_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        cpu_run_q <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (overflow) begin
                        state_q <= ERROR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (accept && stream.in_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q   <= DONE;
                    busy_q    <= 1'b0;
                    cpu_run_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign cpu_run = cpu_run_q;
    assign err     = err_q;

endmodule
